// File: rtl/tariff_engine.sv
// tariff_engine: parking-charge calculator.
// Splits the elapsed time into a low-rate tier and a high-rate tier, multiplies
// each tier by its rate with a serial shift-add multiplier (one multiplier bit
// per cycle), then applies the minimum charge and clamps the result.
// Optional build macro: TARIFF_CAP_EN adds a configurable charge cap
// (CAP_COST) applied after the minimum charge and before the width clamp.
// Without the macro only the output-width clamp exists.

module tariff_engine #(
  parameter int TIME_W      = 8,
  parameter int COST_W      = 12,
  parameter int RATE_LO     = 2,
  parameter int RATE_HI     = 3,
  parameter int TIER_THRESH = 60,
  parameter int MIN_COST    = 2,
  parameter int CAP_COST    = 400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TIME_W-1:0] parking_time,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [COST_W-1:0] cost,
  output logic              saturated
);

  // Accumulator is wide enough that neither tier product nor their sum wraps.
  localparam int ACC_W = TIME_W + COST_W + 2;
  localparam int CNT_W = $clog2(TIME_W + 1);

  localparam logic [ACC_W-1:0] MIN_V     = ACC_W'(MIN_COST);
  localparam logic [ACC_W-1:0] MAX_V     = (ACC_W'(1) << COST_W) - ACC_W'(1);
  localparam logic [ACC_W-1:0] THRESH_V  = ACC_W'(TIER_THRESH);
  localparam logic [ACC_W-1:0] RATE_LO_V = ACC_W'(RATE_LO);
  localparam logic [ACC_W-1:0] RATE_HI_V = ACC_W'(RATE_HI);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TIME_W - 1);

`ifdef TARIFF_CAP_EN
  localparam logic [ACC_W-1:0] CAP_V = ACC_W'(CAP_COST);
`else
  // Keeps the cap parameter referenced; it has no fanout and builds no hardware.
  logic [ACC_W-1:0] w_unused_cap;
  assign w_unused_cap = ACC_W'(CAP_COST);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_LO = 3'd1,
    MUL_HI = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered outputs
  logic              r_req_ready;
  logic              r_res_valid;
  logic [COST_W-1:0] r_cost;
  logic              r_saturated;

  // Datapath registers
  logic [TIME_W-1:0] r_hi;       // high-tier units, held until the second product
  logic [TIME_W-1:0] r_mplier;   // multiplier, consumed LSB first
  logic [ACC_W-1:0]  r_mcand;    // rate, shifted left once per cycle
  logic [ACC_W-1:0]  r_acc_lo;   // low-tier product
  logic [ACC_W-1:0]  r_acc_hi;   // high-tier product
  logic [CNT_W-1:0]  r_cnt;      // multiplier bit index within a phase

  // Combinational helpers
  logic              w_bit_last;
  logic              w_load;
  logic              w_step_lo;
  logic              w_step_hi;
  logic              w_finish;
  logic              w_consume;
  logic [TIME_W-1:0] w_lo;
  logic [TIME_W-1:0] w_hi;
  logic [ACC_W-1:0]  w_addend;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_floor;
  logic [ACC_W-1:0]  w_capped;
  logic              w_cap_hit;
  logic [COST_W-1:0] w_cost_nxt;
  logic              w_sat_nxt;

  assign w_bit_last = (r_cnt == LAST_BIT);
  assign w_addend   = r_mplier[0] ? r_mcand : {ACC_W{1'b0}};

  assign req_ready = r_req_ready;
  assign res_valid = r_res_valid;
  assign cost      = r_cost;
  assign saturated = r_saturated;

  // FSM state register; reset abandons any calculation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: fixed-length multiply phases, then wait for the consumer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt = MUL_LO;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MUL_LO: begin
        if (w_bit_last) begin
          w_state_nxt = MUL_HI;
        end else begin
          w_state_nxt = MUL_LO;
        end
      end
      MUL_HI: begin
        if (w_bit_last) begin
          w_state_nxt = FINAL;
        end else begin
          w_state_nxt = MUL_HI;
        end
      end
      FINAL: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM output decode: per-state datapath strobes.
  always_comb begin
    w_load    = 1'b0;
    w_step_lo = 1'b0;
    w_step_hi = 1'b0;
    w_finish  = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      IDLE:    w_load    = req_valid && r_req_ready;
      MUL_LO:  w_step_lo = 1'b1;
      MUL_HI:  w_step_hi = 1'b1;
      FINAL:   w_finish  = 1'b1;
      DONE:    w_consume = res_ready;
      default: w_load    = 1'b0;
    endcase
  end

  // Tier split of the incoming time: low tier saturates at the threshold.
  always_comb begin
    if (ACC_W'(parking_time) > THRESH_V) begin
      w_lo = TIME_W'(TIER_THRESH);
      w_hi = parking_time - TIME_W'(TIER_THRESH);
    end else begin
      w_lo = parking_time;
      w_hi = {TIME_W{1'b0}};
    end
  end

  // Final charge: add tiers, raise to minimum, optional cap, then width clamp.
  always_comb begin
    w_sum = r_acc_lo + r_acc_hi;
    if (w_sum < MIN_V) begin
      w_floor = MIN_V;
    end else begin
      w_floor = w_sum;
    end
`ifdef TARIFF_CAP_EN
    if (w_floor > CAP_V) begin
      w_capped  = CAP_V;
      w_cap_hit = 1'b1;
    end else begin
      w_capped  = w_floor;
      w_cap_hit = 1'b0;
    end
`else
    w_capped  = w_floor;
    w_cap_hit = 1'b0;
`endif
    if (w_capped > MAX_V) begin
      w_cost_nxt = {COST_W{1'b1}};
      w_sat_nxt  = 1'b1;
    end else begin
      w_cost_nxt = w_capped[COST_W-1:0];
      w_sat_nxt  = w_cap_hit;
    end
  end

  // Handshake flags: ready mirrors the upcoming IDLE state, valid spans DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      if (w_finish) begin
        r_res_valid <= 1'b1;
      end else if (w_consume) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // Result registers: written only in FINAL so they hold outside DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cost      <= {COST_W{1'b0}};
      r_saturated <= 1'b0;
    end else if (w_finish) begin
      r_cost      <= w_cost_nxt;
      r_saturated <= w_sat_nxt;
    end
  end

  // Serial shift-add multiplier shared by both tiers; one bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi     <= {TIME_W{1'b0}};
      r_mplier <= {TIME_W{1'b0}};
      r_mcand  <= {ACC_W{1'b0}};
      r_acc_lo <= {ACC_W{1'b0}};
      r_acc_hi <= {ACC_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (w_load) begin
      r_hi     <= w_hi;
      r_mplier <= w_lo;
      r_mcand  <= RATE_LO_V;
      r_acc_lo <= {ACC_W{1'b0}};
      r_acc_hi <= {ACC_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (w_step_lo) begin
      r_acc_lo <= r_acc_lo + w_addend;
      if (w_bit_last) begin
        // Low-tier product complete: reload the shifter for the high tier.
        r_mplier <= r_hi;
        r_mcand  <= RATE_HI_V;
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_mplier <= r_mplier >> 1;
        r_mcand  <= r_mcand << 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end else if (w_step_hi) begin
      r_acc_hi <= r_acc_hi + w_addend;
      r_mplier <= r_mplier >> 1;
      r_mcand  <= r_mcand << 1;
      if (w_bit_last) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tariff_engine.sv
// Scoreboard bench for tariff_engine: a default-width instance and an 8-bit
// cost instance share all inputs; expected charges come from a tariff model.
`timescale 1ns/1ps

module tb_tariff_engine;

  localparam int RATE_LO_M = 2;
  localparam int RATE_HI_M = 3;
  localparam int THRESH_M  = 60;
  localparam int MIN_M     = 2;
  localparam int CAP_M     = 400;
  localparam int LAT_M     = 17;
  localparam int BOUND     = 200;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [7:0]  parking_time;
  logic        res_ready;
  logic        req_ready, res_valid, saturated;
  logic [11:0] cost;
  logic        req_ready8, res_valid8, saturated8;
  logic [7:0]  cost8;

  typedef struct {
    int c12;
    bit s12;
    int c8;
    bit s8;
    int acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   vecs;

  tariff_engine u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .parking_time(parking_time), .res_valid(res_valid), .res_ready(res_ready),
    .cost(cost), .saturated(saturated)
  );

  tariff_engine #(.COST_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready8),
    .parking_time(parking_time), .res_valid(res_valid8), .res_ready(res_ready),
    .cost(cost8), .saturated(saturated8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tariff rules: two tiers, minimum charge, optional cap, width clamp.
  function automatic void model(input int t, input int cw, output int c, output bit s);
    int lo;
    int sum;
    lo  = (t < THRESH_M) ? t : THRESH_M;
    sum = lo * RATE_LO_M + (t - lo) * RATE_HI_M;
    if (sum < MIN_M) sum = MIN_M;
    s = 1'b0;
`ifdef TARIFF_CAP_EN
    if (sum > CAP_M) begin
      sum = CAP_M;
      s   = 1'b1;
    end
`endif
    if (sum > (1 << cw) - 1) begin
      sum = (1 << cw) - 1;
      s   = 1'b1;
    end
    c = sum;
  endfunction

  // Monitor: compares every presented result against the queue head.
  initial begin
    bit   prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        chk("valid_lockstep", 32'(res_valid8), 32'(res_valid));
        chk("ready_lockstep", 32'(req_ready8), 32'(req_ready));
        if (res_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'(res_valid), 32'd0);
          end else begin
            e = q[0];
            if (!prev_v) chk("latency", 32'(cyc - e.acc_cyc), 32'(LAT_M));
            chk("cost", 32'(cost), 32'(e.c12));
            chk("saturated", 32'(saturated), 32'(e.s12));
            chk("cost8", 32'(cost8), 32'(e.c8));
            chk("saturated8", 32'(saturated8), 32'(e.s8));
            chk("req_ready_in_done", 32'(req_ready), 32'd0);
            if (res_ready) void'(q.pop_front());
          end
        end
        prev_v = res_valid;
      end
    end
  end

  // One transaction; entered #1 after a rising edge. If a previous call chained,
  // req_valid is already high with this time value.
  task automatic do_vec(input int t, input int stall, input bit chain, input int nt);
    int   n;
    exp_t e;
    req_valid    = 1'b1;
    parking_time = 8'(t);
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= BOUND) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    model(t, 12, e.c12, e.s12);
    model(t, 8, e.c8, e.s8);
    e.acc_cyc = cyc;
    q.push_back(e);
    vecs++;
    // Busy-time noise on the request side must be ignored.
    repeat (5) begin
      req_valid    = 1'($urandom_range(0, 1));
      parking_time = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= BOUND) chk("result_timeout", 32'd1, 32'd0);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    if (chain) begin
      req_valid    = 1'b1;
      parking_time = 8'(nt);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int t_cur;
    int nt;
    bit chain;
    n_checks = 0;
    n_fail   = 0;
    vecs     = 0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    res_ready    = 1'b0;
    parking_time = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cost", 32'(cost), 32'd0);
    chk("rst_sat", 32'(saturated), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Directed corners, including a 5-cycle stall chained back-to-back into t=10.
    do_vec(0, 0, 1'b0, 0);
    do_vec(10, 1, 1'b0, 0);
    do_vec(60, 0, 1'b0, 0);
    do_vec(100, 5, 1'b1, 10);
    do_vec(10, 0, 1'b0, 0);
    do_vec(255, 2, 1'b0, 0);
    do_vec(59, 0, 1'b0, 0);
    do_vec(61, 0, 1'b0, 0);
    do_vec(1, 3, 1'b0, 0);

    // Randomized traffic with random stalls and chained requests.
    t_cur = $urandom_range(0, 255);
    for (int i = 0; i < 40; i++) begin
      chain = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      nt    = $urandom_range(0, 255);
      do_vec(t_cur, $urandom_range(0, 5), chain, nt);
      t_cur = chain ? nt : $urandom_range(0, 255);
    end

    // Reset in the middle of a calculation: no result may emerge for it.
    req_valid    = 1'b1;
    parking_time = 8'd200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vecs++;
    repeat (6) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_cost", 32'(cost), 32'd0);
    chk("midrst_sat", 32'(saturated), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_cost8", 32'(cost8), 32'd0);
    #1;
    reset = 1'b0;
    q.delete();
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_result", 32'(res_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    do_vec(10, 0, 1'b0, 0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tariff_engine.md
TARIFF_ENGINE -- requirements
Module: tariff_engine

Interface
REQ-001 SHALL have parameter TIME_W, default 8, parking-time width in time units.
REQ-002 SHALL have parameter COST_W, default 12, cost width.
REQ-003 SHALL have parameter RATE_LO, default 2, cost per unit for units 1..TIER_THRESH.
REQ-004 SHALL have parameter RATE_HI, default 3, cost per unit beyond TIER_THRESH.
REQ-005 SHALL have parameter TIER_THRESH, default 60, tier boundary in time units.
REQ-006 SHALL have parameter MIN_COST, default 2, minimum charge.
REQ-007 SHALL have parameter CAP_COST, default 400, cap value (used only under TARIFF_CAP_EN).
REQ-008 SHALL have port clk  in  1  sole clock, rising edge.
REQ-009 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-010 SHALL have port req_valid  in  1  request present.
REQ-011 SHALL have port req_ready  out  1  engine can accept a request.
REQ-012 SHALL have port parking_time  in  TIME_W  elapsed time, sampled on request acceptance.
REQ-013 SHALL have port res_valid  out  1  result present.
REQ-014 SHALL have port res_ready  in  1  consumer takes result.
REQ-015 SHALL have port cost  out  COST_W  computed charge.
REQ-016 SHALL have port saturated  out  1  cost was clamped (overflow or cap).

Function
REQ-017 SHALL implement FSM states IDLE, MUL_LO, MUL_HI, FINAL, DONE.
REQ-018 req_ready SHALL be high only in IDLE; a request SHALL be accepted on a rising edge with req_valid && req_ready, latching parking_time, IDLE->MUL_LO.
REQ-019 SHALL split the time: lo = min(t, TIER_THRESH), hi = t - lo (zero if t <= TIER_THRESH).
REQ-020 MUL_LO SHALL compute lo*RATE_LO by serial shift-add, one multiplier bit per cycle, exactly TIME_W cycles; MUL_HI SHALL compute hi*RATE_HI the same way, TIME_W cycles.
REQ-021 Internal accumulator SHALL be at least TIME_W+COST_W+2 bits wide; no intermediate overflow.
REQ-022 FINAL (1 cycle) SHALL form sum = lo-product + hi-product, apply min charge (sum < MIN_COST -> MIN_COST), then clamp, then enter DONE.
REQ-023 Clamp: sum > 2^COST_W-1 -> cost = 2^COST_W-1, saturated = 1; else saturated = 0.
REQ-024 res_valid SHALL rise exactly 2*TIME_W+1 rising edges after the acceptance edge (17 at defaults).
REQ-025 In DONE, res_valid SHALL be high and cost/saturated SHALL remain stable until the edge with res_ready high, then return to IDLE with res_valid low.
REQ-026 A new request SHALL NOT be accepted in the same cycle a result is consumed; earliest acceptance is the following edge.
REQ-027 cost and saturated SHALL keep their last values outside DONE; only res_valid qualifies them.
REQ-028 req_valid changes while busy SHALL be ignored; parking_time SHALL NOT be resampled.

Reset
REQ-029 reset high SHALL asynchronously force state IDLE, cost 0, saturated 0, res_valid 0, req_ready 1 (once reset deasserts), clearing all datapath registers.
REQ-030 reset during MUL_LO/MUL_HI/FINAL/DONE SHALL discard the in-flight calculation; no result SHALL be produced for it.

Configuration
REQ-031 With macro TARIFF_CAP_EN defined, FINAL SHALL additionally clamp: sum > CAP_COST -> cost = CAP_COST, saturated = 1 (cap applied after minimum, before width clamp).
REQ-032 Without TARIFF_CAP_EN, no cap logic SHALL exist; only the width clamp of REQ-023 applies; CAP_COST SHALL be unused.

Verification
REQ-033 Defaults, t=0 -> cost 2, saturated 0, res_valid 17 cycles after accept.
REQ-034 Defaults, t=10 -> 20; t=60 -> 120; t=100 -> 240, saturated 0.
REQ-035 Defaults, t=255: with TARIFF_CAP_EN -> cost 400, saturated 1; without -> cost 705, saturated 0.
REQ-036 COST_W=8, no cap, t=255 -> cost 255, saturated 1.
REQ-037 t=100, res_ready low 5 cycles after res_valid -> cost 240 stable, req_ready 0 throughout; then res_ready 1 -> IDLE next edge, back-to-back req with t=10 -> 20.
REQ-038 t=200 accepted, reset pulsed at cycle 6 -> all outputs reset values, no res_valid; subsequent t=10 -> 20.
